// File: rtl/dsp_mac_sequencer_if.sv
// rtl/dsp_mac_sequencer_if.sv - operand stream, result and DSP48A1 slice bundle
// slave is the sequencer side; master is the producer/consumer/slice side.
interface dsp_mac_sequencer_if;
   logic        s_valid;
   logic        s_ready;
   logic [17:0] s_a;
   logic [17:0] s_b;

   logic [17:0] dsp_a;
   logic [17:0] dsp_b;
   logic [7:0]  dsp_opmode;
   logic        dsp_cep;
   logic [47:0] dsp_p;

   logic        res_valid;
   logic        res_ready;
   logic [47:0] res_data;

   modport slave (
      input  s_valid, s_a, s_b,
      output s_ready,
      output dsp_a, dsp_b, dsp_opmode, dsp_cep,
      input  dsp_p,
      output res_valid, res_data,
      input  res_ready
   );

   modport master (
      output s_valid, s_a, s_b,
      input  s_ready,
      input  dsp_a, dsp_b, dsp_opmode, dsp_cep,
      output dsp_p,
      input  res_valid, res_data,
      output res_ready
   );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - sequences one DSP48A1 slice as an N-term dot-product MAC
// Per-pair control rides a 3-stage {valid, first} pipe so OPMODE/CEP line up with M and P.
module dsp_mac_sequencer #(
   parameter int LEN_W = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_neg,
   input  logic             abort,
   output logic             busy,
   dsp_mac_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      RESULT = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [LEN_W-1:0] remaining;
   logic [1:0]       drain_cnt;
   logic             neg_q;
   logic             first_q;
   logic             st0_valid;
   logic             st0_first;
   logic             st1_valid;
   logic [7:0]       opmode_nxt;
   logic             xfer;
   logic             start_acc;
   logic             drain_done;

   assign bus.s_ready   = (state == RUN) && (remaining != '0);
   assign xfer          = bus.s_valid && bus.s_ready;
   assign start_acc     = (state == IDLE) && start && !abort;
   assign drain_done    = (state == DRAIN) && (drain_cnt == 2'd3);
   assign busy          = (state != IDLE);
   assign bus.res_valid = (state == RESULT);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = (cfg_len == '0) ? RESULT : RUN;
            RUN:     if (xfer && (remaining == LEN_W'(1))) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'd3) state_nxt = RESULT;
            RESULT:  if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // First pair of a job uses Z=0 so any stale P (e.g. after abort) is discarded.
   always_comb begin
      opmode_nxt = 8'h00;
      if (st0_valid) begin
         opmode_nxt = st0_first ? 8'h01 : 8'h09;
         opmode_nxt[7] = neg_q;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         remaining      <= '0;
         drain_cnt      <= 2'd0;
         neg_q          <= 1'b0;
         first_q        <= 1'b0;
         st0_valid      <= 1'b0;
         st0_first      <= 1'b0;
         st1_valid      <= 1'b0;
         bus.dsp_opmode <= 8'h00;
         bus.dsp_cep    <= 1'b0;
         bus.dsp_a      <= 18'd0;
         bus.dsp_b      <= 18'd0;
         bus.res_data   <= 48'd0;
      end else begin
         if (xfer) begin
            bus.dsp_a <= bus.s_a;
            bus.dsp_b <= bus.s_b;
         end
         if (abort) begin
            remaining      <= '0;
            drain_cnt      <= 2'd0;
            first_q        <= 1'b0;
            st0_valid      <= 1'b0;
            st0_first      <= 1'b0;
            st1_valid      <= 1'b0;
            bus.dsp_opmode <= 8'h00;
            bus.dsp_cep    <= 1'b0;
         end else begin
            if (start_acc) begin
               remaining <= cfg_len;
               neg_q     <= cfg_neg;
               first_q   <= 1'b1;
            end else if (xfer) begin
               remaining <= remaining - LEN_W'(1);
               first_q   <= 1'b0;
            end
            drain_cnt      <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            st0_valid      <= xfer;
            st0_first      <= xfer && first_q;
            st1_valid      <= st0_valid;
            bus.dsp_opmode <= opmode_nxt;
            bus.dsp_cep    <= st1_valid;
            if (start_acc && (cfg_len == '0)) begin
               bus.res_data <= 48'd0;
            end else if (drain_done) begin
               bus.res_data <= bus.dsp_p;
            end
         end
      end
   end

endmodule
